// File: rtl/cbc_stream_encryptor_if.sv
// Handshake bundle for the CBC nibble-stream encryptor: message control,
// plaintext nibble input stream and ciphertext word output stream.
interface cbc_stream_encryptor_if;
    logic       start;
    logic [3:0] k;
    logic [3:0] iv;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_c;
    logic [3:0] out_iv;
    logic       out_last;
    logic       busy;

    modport master (
        output start, k, iv, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_c, out_iv, out_last, busy
    );

    modport slave (
        input  start, k, iv, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_c, out_iv, out_last, busy
    );
endinterface

// File: rtl/cbc_stream_encryptor.sv
// CBC encryptor: packs two encrypted 4-bit blocks per output byte, zero-pads an
// odd final nibble, and reports the chaining value preceding the upper block.
module cbc_stream_encryptor (
    input  logic                   clk,
    input  logic                   reset,
    cbc_stream_encryptor_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    function automatic logic [3:0] enc_block(input logic [3:0] x, input logic [3:0] key);
        logic [3:0] t;
        t = x ^ key;
        return {t[2:0], t[3]};
    endfunction

    state_e     state_q, state_d;
    logic [3:0] key_q, key_d;
    logic [3:0] ch_q, ch_d;
    logic [7:0] out_c_q, out_c_d;
    logic [3:0] out_iv_q, out_iv_d;
    logic       out_last_q, out_last_d;
    logic       in_ready_q, out_valid_q, busy_q;
    logic       in_xfer_s;
    logic [3:0] blk_s;
    logic [3:0] pad_s;

    assign in_xfer_s = bus.in_valid && in_ready_q;
    assign blk_s     = enc_block(bus.in_data ^ ch_q, key_q);
    // Padding plaintext is zero, so the padded block is E_k(c_hi).
    assign pad_s     = enc_block(blk_s, key_q);

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        ch_d       = ch_q;
        out_c_d    = out_c_q;
        out_iv_d   = out_iv_q;
        out_last_d = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    key_d   = bus.k;
                    ch_d    = bus.iv;
                    state_d = ST_HI;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HI: begin
                if (in_xfer_s) begin
                    out_c_d[7:4] = blk_s;
                    out_iv_d     = ch_q;
                    if (bus.in_last) begin
                        out_c_d[3:0] = pad_s;
                        out_last_d   = 1'b1;
                        ch_d         = pad_s;
                        state_d      = ST_OUT;
                    end else begin
                        out_last_d   = 1'b0;
                        ch_d         = blk_s;
                        state_d      = ST_LO;
                    end
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_LO: begin
                if (in_xfer_s) begin
                    out_c_d[3:0] = blk_s;
                    out_last_d   = bus.in_last;
                    ch_d         = blk_s;
                    state_d      = ST_OUT;
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = out_last_q ? ST_IDLE : ST_HI;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered handshake decodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            key_q       <= 4'h0;
            ch_q        <= 4'h0;
            out_c_q     <= 8'h00;
            out_iv_q    <= 4'h0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            ch_q        <= ch_d;
            out_c_q     <= out_c_d;
            out_iv_q    <= out_iv_d;
            out_last_q  <= out_last_d;
            in_ready_q  <= (state_d == ST_HI) || (state_d == ST_LO);
            out_valid_q <= (state_d == ST_OUT);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_iv    = out_iv_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
endmodule
